// File: rtl/rename_freelist_ctrl.sv
// -----------------------------------------------------------------------------
// rename_freelist_ctrl
//
// Physical-register free list for the integer rename stage. Free tags live in a
// circular buffer addressed by three wrapping pointers:
//   head        - speculative allocate pointer (moves on grants)
//   commit_head - architecturally committed allocate pointer
//   tail        - release pointer (moves on retiring frees)
// Pointers carry one extra wrap bit so tail - head spans 0..DEPTH.
//
// After reset an init sequencer seeds INIT_COUNT tags (INIT_BASE + k*INIT_STRIDE)
// and then enters RUN. A flush rewinds head to commit_head and spends one RECOVER
// cycle without grants before returning to RUN.
//
// Ports:
//   Clk            clock
//   Rest           asynchronous active-low reset
//   AllocReq[1:0]  per-lane allocate request, bit0 = older lane
//   AllocGnt[1:0]  per-lane grant (combinational)
//   AllocTag0/1    tag offered to lane0 / lane1
//   FreeVld[1:0]   retiring-tag valid per slot
//   FreeTag0/1     retiring tags
//   CommitAllocNum allocations committed this cycle (0..2)
//   Flush          squash speculative allocations
//   Ready          RUN state and no flush this cycle
//   FreeCount      tail - head
//   FreeErr        one-cycle registered pulse on free overflow / commit past head
//   StallCnt       (only with FREELIST_STATS_EN) saturating count of stalled
//                  RUN cycles where a requesting lane was not granted
//
// Optional feature macro: FREELIST_STATS_EN
// -----------------------------------------------------------------------------
module rename_freelist_ctrl #(
    parameter int TAGW        = 7,
    parameter int DEPTH       = 32,
    parameter int PTRW        = 6,
    parameter int INIT_BASE   = 35,
    parameter int INIT_STRIDE = 4,
    parameter int INIT_COUNT  = 24
) (
    input  logic            Clk,
    input  logic            Rest,
    input  logic [1:0]      AllocReq,
    output logic [1:0]      AllocGnt,
    output logic [TAGW-1:0] AllocTag0,
    output logic [TAGW-1:0] AllocTag1,
    input  logic [1:0]      FreeVld,
    input  logic [TAGW-1:0] FreeTag0,
    input  logic [TAGW-1:0] FreeTag1,
    input  logic [1:0]      CommitAllocNum,
    input  logic            Flush,
    output logic            Ready,
    output logic [PTRW-1:0] FreeCount,
    output logic            FreeErr
`ifdef FREELIST_STATS_EN
    ,
    output logic [31:0]     StallCnt
`endif
);
    localparam int IDXW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [PTRW-1:0] head_reg, head_next;
    logic [PTRW-1:0] commit_head_reg, commit_head_next;
    logic [PTRW-1:0] tail_reg, tail_next;
    logic [PTRW-1:0] init_cnt_reg, init_cnt_next;
    logic            free_err_reg, free_err_next;

    // Tag storage; contents are deliberately not reset (the init sequencer seeds it)
    logic [TAGW-1:0] entry_mem [DEPTH];

    logic [PTRW-1:0] free_cnt;
    logic            seeding;
    logic            active;
    logic            run_alloc;
    logic            gnt0, gnt1;
    logic [1:0]      gnt_num;
    logic [1:0]      free_num;
    logic [PTRW:0]   free_sum;
    logic            free_drop;
    logic            free_ok;
    logic [PTRW-1:0] commit_dist;
    logic            commit_ovf;
    logic [PTRW-1:0] commit_adv;
    logic [PTRW-1:0] head_p1;
    logic [TAGW-1:0] seed_tag;
    logic            wr0_en, wr1_en;
    logic [IDXW-1:0] wr0_idx, wr1_idx;
    logic [TAGW-1:0] wr0_data;

    // FreeCount is derived from registered pointers only: frees landing this
    // cycle are not visible to this cycle's grants.
    assign free_cnt  = tail_reg - head_reg;
    assign seeding   = (state_reg == ST_INIT);
    assign active    = !seeding;
    assign run_alloc = (state_reg == ST_RUN) && !Flush;

    // In-order grant: lane1 can only take the second tag when lane0 is also
    // requesting and granted; a lone lane1 request takes the head tag.
    assign gnt0 = run_alloc && AllocReq[0] && (free_cnt >= PTRW'(1));
    assign gnt1 = run_alloc && AllocReq[1] &&
                  (AllocReq[0] ? (gnt0 && (free_cnt >= PTRW'(2)))
                               : (free_cnt >= PTRW'(1)));
    assign gnt_num  = {1'b0, gnt0} + {1'b0, gnt1};
    assign AllocGnt = {gnt1, gnt0};

    assign head_p1   = head_reg + PTRW'(1);
    assign AllocTag0 = entry_mem[head_reg[IDXW-1:0]];
    assign AllocTag1 = AllocReq[0] ? entry_mem[head_p1[IDXW-1:0]]
                                   : entry_mem[head_reg[IDXW-1:0]];

    // A cycle whose frees would overfill the buffer is dropped as a whole
    assign free_num  = {1'b0, FreeVld[0]} + {1'b0, FreeVld[1]};
    assign free_sum  = {1'b0, free_cnt} + (PTRW+1)'(free_num);
    assign free_drop = free_sum > (PTRW+1)'(DEPTH);
    assign free_ok   = active && !free_drop;

    // Commit may not overtake the speculative head; saturate there instead
    assign commit_dist = head_reg - commit_head_reg;
    assign commit_ovf  = PTRW'(CommitAllocNum) > commit_dist;
    assign commit_adv  = commit_ovf ? head_reg
                                    : commit_head_reg + PTRW'(CommitAllocNum);

    assign seed_tag = TAGW'(INIT_BASE + INIT_STRIDE * int'(init_cnt_reg));

    // Two write ports: port0 serves seeding or free slot 0, port1 serves free
    // slot 1 compacted behind slot 0.
    assign wr0_en   = seeding || (free_ok && FreeVld[0]);
    assign wr0_idx  = tail_reg[IDXW-1:0];
    assign wr0_data = seeding ? seed_tag : FreeTag0;
    assign wr1_en   = free_ok && FreeVld[1];
    assign wr1_idx  = tail_reg[IDXW-1:0] + IDXW'(FreeVld[0]);

    always_ff @(posedge Clk) begin
        if (wr0_en) entry_mem[wr0_idx] <= wr0_data;
        if (wr1_en) entry_mem[wr1_idx] <= FreeTag1;
    end

    always_comb begin
        state_next       = state_reg;
        head_next        = head_reg;
        commit_head_next = commit_head_reg;
        tail_next        = tail_reg;
        init_cnt_next    = init_cnt_reg;
        free_err_next    = 1'b0;
        case (state_reg)
            ST_INIT: begin
                tail_next     = tail_reg + PTRW'(1);
                init_cnt_next = init_cnt_reg + PTRW'(1);
                if (init_cnt_reg == PTRW'(INIT_COUNT - 1)) state_next = ST_RUN;
            end
            default: begin
                commit_head_next = commit_adv;
                tail_next        = tail_reg + (free_drop ? PTRW'(0) : PTRW'(free_num));
                free_err_next    = free_drop || commit_ovf;
                if (Flush) begin
                    // Rewind to the commit point including this cycle's commits
                    head_next  = commit_adv;
                    state_next = ST_RECOVER;
                end else begin
                    head_next  = head_reg + PTRW'(gnt_num);
                    state_next = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            state_reg       <= ST_INIT;
            head_reg        <= '0;
            commit_head_reg <= '0;
            tail_reg        <= '0;
            init_cnt_reg    <= '0;
            free_err_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            head_reg        <= head_next;
            commit_head_reg <= commit_head_next;
            tail_reg        <= tail_next;
            init_cnt_reg    <= init_cnt_next;
            free_err_reg    <= free_err_next;
        end
    end

    assign Ready     = (state_reg == ST_RUN) && !Flush;
    assign FreeCount = free_cnt;
    assign FreeErr   = free_err_reg;

`ifdef FREELIST_STATS_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            stall_cnt_reg <= '0;
        end else if (run_alloc && ((AllocReq & ~AllocGnt) != 2'b00) &&
                     (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign StallCnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_rename_freelist_ctrl.sv
module tb_rename_freelist_ctrl;

    logic       clk = 1'b0;
    logic       rest_n = 1'b0;
    logic [1:0] alloc_req = 2'b00;
    logic [1:0] alloc_gnt;
    logic [6:0] alloc_tag0, alloc_tag1;
    logic [1:0] free_vld = 2'b00;
    logic [6:0] free_tag0 = 7'd0;
    logic [6:0] free_tag1 = 7'd0;
    logic [1:0] commit_num = 2'b00;
    logic       flush = 1'b0;
    logic       ready;
    logic [5:0] free_count;
    logic       free_err;
`ifdef FREELIST_STATS_EN
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rename_freelist_ctrl dut (
        .Clk            (clk),
        .Rest           (rest_n),
        .AllocReq       (alloc_req),
        .AllocGnt       (alloc_gnt),
        .AllocTag0      (alloc_tag0),
        .AllocTag1      (alloc_tag1),
        .FreeVld        (free_vld),
        .FreeTag0       (free_tag0),
        .FreeTag1       (free_tag1),
        .CommitAllocNum (commit_num),
        .Flush          (flush),
        .Ready          (ready),
        .FreeCount      (free_count),
        .FreeErr        (free_err)
`ifdef FREELIST_STATS_EN
        ,
        .StallCnt       (stall_cnt)
`endif
    );

    typedef struct {
        int req;
        int fvld;
        int ft0;
        int ft1;
        int egnt;
        int etag0;   // -1 = don't care
        int etag1;   // -1 = don't care
        int efc;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One transaction: drive at the falling edge, outputs settle 1 time unit later
    task automatic cyc(input logic [1:0] req, input logic [1:0] fv, input logic [6:0] t0,
                       input logic [6:0] t1, input logic [1:0] cn, input logic fl);
        @(negedge clk);
        alloc_req  = req;
        free_vld   = fv;
        free_tag0  = t0;
        free_tag1  = t1;
        commit_num = cn;
        flush      = fl;
        #1;
        $display("txn req=%b fvld=%b cnum=%0d flush=%0b -> gnt=%b tag0=%0d tag1=%0d fc=%0d rdy=%0b ferr=%0b",
                 req, fv, cn, fl, alloc_gnt, alloc_tag0, alloc_tag1, free_count, ready, free_err);
    endtask

    task automatic idle_inputs();
        alloc_req  = 2'b00;
        free_vld   = 2'b00;
        free_tag0  = 7'd0;
        free_tag1  = 7'd0;
        commit_num = 2'b00;
        flush      = 1'b0;
    endtask

    // Reset, release, and wait out the 24-cycle seeding sequence
    task automatic do_reset_init();
        @(negedge clk);
        idle_inputs();
        rest_n = 1'b0;
        repeat (2) @(negedge clk);
        rest_n = 1'b1;
        repeat (24) @(negedge clk);
        #1;
        chk("init_ready", int'(ready), 1);
        $display("txn reset+init done fc=%0d rdy=%0b", free_count, ready);
    endtask

    function automatic int seq_b_tag(input int p);
        if (p < 24) return 35 + 4 * p;
        if (p == 31) return 9;
        return 100 + (p - 24);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int q_tags[$];
        int spec_n;
        bit m_run;
        int m_err_prev;
        logic [1:0] r_req, r_fv, r_cn;
        logic [6:0] r_t0, r_t1;
        logic r_fl;
        int fc, nf, g0, g1, err, cn_i;

        // ---------------- reset values and init sequence ----------------
        idle_inputs();
        alloc_req = 2'b11;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", int'(ready), 0);
        chk("rst_gnt", int'(alloc_gnt), 0);
        chk("rst_free_err", int'(free_err), 0);
        chk("rst_free_count", int'(free_count), 0);
        rest_n = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k <= 20) begin
                // Traffic during seeding must be ignored
                alloc_req  = 2'($urandom_range(0, 3));
                free_vld   = 2'($urandom_range(0, 3));
                free_tag0  = 7'($urandom_range(0, 127));
                free_tag1  = 7'($urandom_range(0, 127));
                commit_num = 2'($urandom_range(0, 2));
                flush      = 1'($urandom_range(0, 1));
            end else begin
                idle_inputs();
                alloc_req = 2'b11;
            end
            #1;
            $display("txn init k=%0d rdy=%0b fc=%0d gnt=%b", k, ready, free_count, alloc_gnt);
            chk("init_ready_k", int'(ready), (k == 24) ? 1 : 0);
            chk("init_free_count", int'(free_count), k);
            chk("init_free_err", int'(free_err), 0);
            if (k < 24) chk("init_gnt", int'(alloc_gnt), 0);
        end
        chk("first_gnt", int'(alloc_gnt), 3);
        chk("first_tag0", int'(alloc_tag0), 35);
        chk("first_tag1", int'(alloc_tag1), 39);
        alloc_req = 2'b00;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 12; i++)
            vecs[i] = '{req: 3, fvld: 0, ft0: 0, ft1: 0, egnt: 3,
                        etag0: 35 + 8 * i, etag1: 39 + 8 * i, efc: 24 - 2 * i};
        vecs[12] = '{req: 3, fvld: 0, ft0: 0,  ft1: 0,  egnt: 0, etag0: -1, etag1: -1, efc: 0};
        vecs[13] = '{req: 1, fvld: 0, ft0: 0,  ft1: 0,  egnt: 0, etag0: -1, etag1: -1, efc: 0};
        vecs[14] = '{req: 0, fvld: 1, ft0: 5,  ft1: 0,  egnt: 0, etag0: -1, etag1: -1, efc: 0};
        vecs[15] = '{req: 3, fvld: 0, ft0: 0,  ft1: 0,  egnt: 1, etag0: 5,  etag1: -1, efc: 1};
        vecs[16] = '{req: 0, fvld: 1, ft0: 6,  ft1: 0,  egnt: 0, etag0: -1, etag1: -1, efc: 0};
        vecs[17] = '{req: 2, fvld: 0, ft0: 0,  ft1: 0,  egnt: 2, etag0: -1, etag1: 6,  efc: 1};
        vecs[18] = '{req: 0, fvld: 3, ft0: 20, ft1: 21, egnt: 0, etag0: -1, etag1: -1, efc: 0};
        vecs[19] = '{req: 2, fvld: 0, ft0: 0,  ft1: 0,  egnt: 2, etag0: -1, etag1: 20, efc: 2};
        vecs[20] = '{req: 3, fvld: 0, ft0: 0,  ft1: 0,  egnt: 1, etag0: 21, etag1: -1, efc: 1};

        for (int v = 0; v < 21; v++) begin
            cyc(2'(vecs[v].req), 2'(vecs[v].fvld), 7'(vecs[v].ft0), 7'(vecs[v].ft1), 2'b00, 1'b0);
            chk("vec_gnt", int'(alloc_gnt), vecs[v].egnt);
            chk("vec_free_count", int'(free_count), vecs[v].efc);
            chk("vec_ready", int'(ready), 1);
            chk("vec_free_err", int'(free_err), 0);
            if (vecs[v].etag0 >= 0) chk("vec_tag0", int'(alloc_tag0), vecs[v].etag0);
            if (vecs[v].etag1 >= 0) chk("vec_tag1", int'(alloc_tag1), vecs[v].etag1);
        end

        // ---------------- flush / recover sequence ----------------
        do_reset_init();
        repeat (3) cyc(2'b11, 2'b00, 7'd0, 7'd0, 2'd0, 1'b0);
        cyc(2'b00, 2'b00, 7'd0, 7'd0, 2'd2, 1'b0);
        cyc(2'b11, 2'b00, 7'd0, 7'd0, 2'd0, 1'b1);
        chk("flush_ready", int'(ready), 0);
        chk("flush_gnt", int'(alloc_gnt), 0);
        cyc(2'b11, 2'b00, 7'd0, 7'd0, 2'd0, 1'b0);
        chk("recover_ready", int'(ready), 0);
        chk("recover_gnt", int'(alloc_gnt), 0);
        chk("recover_free_count", int'(free_count), 22);
        cyc(2'b01, 2'b00, 7'd0, 7'd0, 2'd0, 1'b0);
        chk("after_flush_ready", int'(ready), 1);
        chk("after_flush_gnt", int'(alloc_gnt), 1);
        chk("after_flush_tag0", int'(alloc_tag0), 43);
        chk("after_flush_free_count", int'(free_count), 22);
        // Flush again while recovering keeps the block in RECOVER
        cyc(2'b00, 2'b00, 7'd0, 7'd0, 2'd0, 1'b1);
        cyc(2'b00, 2'b00, 7'd0, 7'd0, 2'd0, 1'b1);
        chk("reflush_free_count", int'(free_count), 22);
        cyc(2'b11, 2'b00, 7'd0, 7'd0, 2'd0, 1'b0);
        chk("reflush_stay_recover", int'(ready), 0);
        chk("reflush_gnt", int'(alloc_gnt), 0);
        cyc(2'b11, 2'b00, 7'd0, 7'd0, 2'd0, 1'b0);
        chk("reflush_run_ready", int'(ready), 1);
        chk("reflush_tag0", int'(alloc_tag0), 43);
        chk("reflush_tag1", int'(alloc_tag1), 47);

        // ---------------- free overflow sequence ----------------
        do_reset_init();
        cyc(2'b00, 2'b11, 7'd100, 7'd101, 2'd0, 1'b0);
        cyc(2'b00, 2'b11, 7'd102, 7'd103, 2'd0, 1'b0);
        cyc(2'b00, 2'b11, 7'd104, 7'd105, 2'd0, 1'b0);
        cyc(2'b00, 2'b01, 7'd106, 7'd0, 2'd0, 1'b0);
        cyc(2'b00, 2'b11, 7'd50, 7'd51, 2'd0, 1'b0);
        chk("ovf_pre_free_count", int'(free_count), 31);
        chk("ovf_pre_err", int'(free_err), 0);
        cyc(2'b00, 2'b10, 7'd0, 7'd9, 2'd0, 1'b0);
        chk("ovf_err_pulse", int'(free_err), 1);
        chk("ovf_tail_kept", int'(free_count), 31);
        cyc(2'b00, 2'b00, 7'd0, 7'd0, 2'd0, 1'b0);
        chk("ovf_err_clear", int'(free_err), 0);
        chk("ovf_slot1_free", int'(free_count), 32);
        for (int i = 0; i < 16; i++) begin
            cyc(2'b11, 2'b00, 7'd0, 7'd0, 2'd0, 1'b0);
            chk("drain_gnt", int'(alloc_gnt), 3);
            chk("drain_tag0", int'(alloc_tag0), seq_b_tag(2 * i));
            chk("drain_tag1", int'(alloc_tag1), seq_b_tag(2 * i + 1));
        end
        cyc(2'b00, 2'b00, 7'd0, 7'd0, 2'd0, 1'b0);
        chk("drain_empty", int'(free_count), 0);

        // ---------------- commit past head + mid-traffic reset ----------------
        do_reset_init();
        cyc(2'b00, 2'b00, 7'd0, 7'd0, 2'd2, 1'b0);
        chk("cpast_pre_err", int'(free_err), 0);
        cyc(2'b01, 2'b00, 7'd0, 7'd0, 2'd0, 1'b0);
        chk("cpast_err_pulse", int'(free_err), 1);
        chk("cpast_tag0", int'(alloc_tag0), 35);
        cyc(2'b00, 2'b00, 7'd0, 7'd0, 2'd0, 1'b1);
        chk("cpast_err_clear", int'(free_err), 0);
        cyc(2'b00, 2'b00, 7'd0, 7'd0, 2'd0, 1'b0);
        cyc(2'b11, 2'b00, 7'd0, 7'd0, 2'd0, 1'b0);
        chk("cpast_commit_kept", int'(free_count), 24);
        chk("cpast_tag0_after", int'(alloc_tag0), 35);
        cyc(2'b00, 2'b00, 7'd0, 7'd0, 2'd2, 1'b0);
        cyc(2'b11, 2'b00, 7'd0, 7'd0, 2'd1, 1'b0);
        @(negedge clk);
        #1;
        chk("midrst_err_before", int'(free_err), 1);
        rest_n = 1'b0;
        #1;
        $display("txn reset asserted mid-traffic rdy=%0b gnt=%b fc=%0d ferr=%0b",
                 ready, alloc_gnt, free_count, free_err);
        chk("midrst_ready", int'(ready), 0);
        chk("midrst_gnt", int'(alloc_gnt), 0);
        chk("midrst_free_count", int'(free_count), 0);
        chk("midrst_free_err", int'(free_err), 0);
        @(negedge clk);
        idle_inputs();
        rest_n = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            #1;
            chk("reinit_ready", int'(ready), (k == 24) ? 1 : 0);
        end
        cyc(2'b11, 2'b00, 7'd0, 7'd0, 2'd0, 1'b0);
        chk("reinit_tag0", int'(alloc_tag0), 35);
        chk("reinit_tag1", int'(alloc_tag1), 39);
        chk("reinit_free_count", int'(free_count), 24);

        // ---------------- randomized run against a queue model ----------------
        // The model keeps the buffer as a queue of tags from the commit point to
        // the tail; spec_n counts speculatively allocated entries at its front.
        do_reset_init();
        q_tags.delete();
        for (int k = 0; k < 24; k++) q_tags.push_back((35 + 4 * k) % 128);
        spec_n = 0;
        m_run = 1'b1;
        m_err_prev = 0;
        for (int c = 0; c < 400; c++) begin
            r_req = 2'($urandom_range(0, 3));
            r_fv  = 2'($urandom_range(0, 3));
            r_t0  = 7'($urandom_range(0, 127));
            r_t1  = 7'($urandom_range(0, 127));
            r_fl  = ($urandom_range(0, 11) == 0);
            cn_i  = $urandom_range(0, 2);
            if ($urandom_range(0, 6) != 0 && cn_i > spec_n) cn_i = spec_n;
            r_cn  = 2'(cn_i);
            fc = q_tags.size() - spec_n;
            nf = int'(r_fv[0]) + int'(r_fv[1]);
            // Unique tags can never overfill the buffer past the commit point
            if (fc + nf <= 32 && q_tags.size() + nf > 32) begin
                r_fv = 2'b00;
                nf = 0;
            end
            cyc(r_req, r_fv, r_t0, r_t1, r_cn, r_fl);

            g0 = (m_run && !r_fl && r_req[0] && fc >= 1) ? 1 : 0;
            if (m_run && !r_fl && r_req[1])
                g1 = r_req[0] ? ((g0 == 1 && fc >= 2) ? 1 : 0) : ((fc >= 1) ? 1 : 0);
            else
                g1 = 0;
            chk("rnd_ready", int'(ready), (m_run && !r_fl) ? 1 : 0);
            chk("rnd_gnt", int'(alloc_gnt), g1 * 2 + g0);
            chk("rnd_free_count", int'(free_count), fc);
            chk("rnd_free_err", int'(free_err), m_err_prev);
            if (g0 == 1) chk("rnd_tag0", int'(alloc_tag0), q_tags[spec_n]);
            if (g1 == 1) chk("rnd_tag1", int'(alloc_tag1), q_tags[r_req[0] ? spec_n + 1 : spec_n]);

            err = 0;
            if (cn_i > spec_n) begin
                err = 1;
                repeat (spec_n) void'(q_tags.pop_front());
                spec_n = 0;
            end else begin
                repeat (cn_i) void'(q_tags.pop_front());
                spec_n -= cn_i;
            end
            if (fc + nf > 32) begin
                err = 1;
            end else begin
                if (r_fv[0]) q_tags.push_back(int'(r_t0));
                if (r_fv[1]) q_tags.push_back(int'(r_t1));
            end
            spec_n += g0 + g1;
            if (r_fl) begin
                spec_n = 0;
                m_run = 1'b0;
            end else begin
                m_run = 1'b1;
            end
            m_err_prev = err;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
